sipo_reorder: RTL and testbench



---
 rtl/viterbi_pkg.sv | 13 +
 rtl/sipo_out_slot.sv | 48 ++++
 rtl/sipo_reorder.sv | 155 +++++++++++++++
 tb/tb_sipo_reorder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi traceback output path.
// Holds the default frame length, collector state encoding and drop-counter width.
package viterbi_pkg;

   localparam int TBL_DEF    = 15;
   localparam int DROP_CNT_W = 8;

   typedef enum logic {
      COLLECT = 1'b0,
      DROP    = 1'b1
   } coll_state_e;

endpackage

// File: rtl/sipo_out_slot.sv
// Single-entry output register with valid/ready hold.
// A load takes priority over a same-cycle handshake so a new word can replace one leaving.
module sipo_out_slot
   import viterbi_pkg::*;
#(
   parameter int W = TBL_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         free_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // Next slot contents: load, drain on handshake, or hold.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Slot register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/sipo_reorder.sv
// Serial-to-parallel reorder of traceback bits into frames, newest bit first in.
// Optional SIPO_DROP_CNT_EN adds a saturating dropped-frame counter on drop_cnt_o.
module sipo_reorder
   import viterbi_pkg::*;
#(
   parameter int TBL   = TBL_DEF,
   parameter int OUT_W = TBL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_serial_i,
   input  logic             valid_serial_i,
   output logic [OUT_W-1:0] data_parallel_o,
   output logic             valid_parallel_o,
   input  logic             ready_parallel_i,
   output logic             overflow_o
`ifdef SIPO_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

   localparam int CW = (TBL > 2) ? $clog2(TBL) : 1;
   localparam logic [CW-1:0] LAST = CW'(TBL - 1);

   coll_state_e  state_q, state_d;
   logic [TBL-1:0] shreg_q, shreg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic           ovf_q, ovf_d;

   logic           load;
   logic [TBL-1:0] load_data;
   logic [TBL-1:0] shifted;
   logic           slot_free;
   logic           hs;

   assign shifted = {shreg_q[TBL-2:0], data_serial_i};
   assign hs      = valid_parallel_o && ready_parallel_i;

   // Collector FSM: assemble, park a finished frame in pend, or discard a frame.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      ovf_d     = 1'b0;
      load      = 1'b0;
      load_data = shifted;
      unique case (state_q)
         COLLECT: begin
            if (pend_q) begin
               if (hs) begin
                  load      = 1'b1;
                  load_data = shreg_q;
                  pend_d    = 1'b0;
                  if (valid_serial_i) begin
                     shreg_d = shifted;
                     cnt_d   = CW'(1);
                  end
               end else if (valid_serial_i) begin
                  state_d = DROP;
                  ovf_d   = 1'b1;
                  cnt_d   = CW'(1);
               end
            end else if (valid_serial_i) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (slot_free) begin
                     load = 1'b1;
                  end else begin
                     shreg_d = shifted;
                     pend_d  = 1'b1;
                  end
               end else begin
                  shreg_d = shifted;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         DROP: begin
            if (pend_q && hs) begin
               load      = 1'b1;
               load_data = shreg_q;
               pend_d    = 1'b0;
            end
            if (valid_serial_i) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = COLLECT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Collector state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         shreg_q <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign overflow_o = ovf_q;

   sipo_out_slot #(
      .W (OUT_W)
   ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .data_i  (load_data),
      .ready_i (ready_parallel_i),
      .data_o  (data_parallel_o),
      .valid_o (valid_parallel_o),
      .free_o  (slot_free)
   );

`ifdef SIPO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Saturating dropped-frame counter.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ovf_d && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sipo_reorder.sv
// Directed self-checking bench for sipo_reorder with TBL=15.
// Drop-counter checks are active when SIPO_DROP_CNT_EN is defined.
module tb_sipo_reorder;

   localparam int TBL = 15;

   logic           clk;
   logic           rst_n;
   logic           data_serial_i;
   logic           valid_serial_i;
   logic [TBL-1:0] data_parallel_o;
   logic           valid_parallel_o;
   logic           ready_parallel_i;
   logic           overflow_o;
`ifdef SIPO_DROP_CNT_EN
   logic [7:0]     drop_cnt_o;
`endif

   int n_chk;
   int n_fail;
   int ovf_cnt;
   int ovf_base;

   sipo_reorder #(
      .TBL   (TBL),
      .OUT_W (TBL)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_serial_i    (data_serial_i),
      .valid_serial_i   (valid_serial_i),
      .data_parallel_o  (data_parallel_o),
      .valid_parallel_o (valid_parallel_o),
      .ready_parallel_i (ready_parallel_i),
      .overflow_o       (overflow_o)
`ifdef SIPO_DROP_CNT_EN
      ,
      .drop_cnt_o       (drop_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && overflow_o) ovf_cnt <= ovf_cnt + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      data_serial_i  = b;
      valid_serial_i = 1'b1;
      step();
      valid_serial_i = 1'b0;
   endtask

   task automatic send_frame(input logic [TBL-1:0] w, input bit gaps);
      for (int i = TBL - 1; i >= 0; i--) begin
         send_bit(w[i]);
         if (gaps && (i > 0) && (((TBL - 1 - i) % 4) == 3)) begin
            repeat (3) step();
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [TBL-1:0] w;
      n_chk            = 0;
      n_fail           = 0;
      ovf_cnt          = 0;
      rst_n            = 1'b0;
      data_serial_i    = 1'b0;
      valid_serial_i   = 1'b0;
      ready_parallel_i = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;

      check("rst_data", 32'(data_parallel_o), 32'h0);
      check("rst_valid", 32'(valid_parallel_o), 32'h0);
      check("rst_ovf", 32'(overflow_o), 32'h0);

      // Single frame, ready high, latency of one cycle.
      ready_parallel_i = 1'b1;
      w = 15'h4000;
      for (int i = TBL - 1; i >= 1; i--) send_bit(w[i]);
      check("t1_pre_valid", 32'(valid_parallel_o), 32'h0);
      send_bit(w[0]);
      check("t1_valid", 32'(valid_parallel_o), 32'h1);
      check("t1_data", 32'(data_parallel_o), 32'h4000);
      step();
      check("t1_valid_clr", 32'(valid_parallel_o), 32'h0);

      // Gapped input frame.
      send_frame(15'h2AAA, 1'b1);
      check("t2_valid", 32'(valid_parallel_o), 32'h1);
      check("t2_data", 32'(data_parallel_o), 32'h2AAA);
      step();
      check("t2_valid_clr", 32'(valid_parallel_o), 32'h0);

      // Held, pending, dropped.
      ready_parallel_i = 1'b0;
      ovf_base = ovf_cnt;
      send_frame(15'h0001, 1'b0);
      check("t3_a_valid", 32'(valid_parallel_o), 32'h1);
      check("t3_a_data", 32'(data_parallel_o), 32'h0001);
      send_frame(15'h7FFE, 1'b0);
      check("t3_a_held", 32'(data_parallel_o), 32'h0001);
      check("t3_ovf_none", 32'(overflow_o), 32'h0);
      w = 15'h1357;
      send_bit(w[TBL-1]);
      check("t3_ovf_pulse", 32'(overflow_o), 32'h1);
      for (int i = TBL - 2; i >= 0; i--) send_bit(w[i]);
      check("t3_ovf_low", 32'(overflow_o), 32'h0);
      check("t3_ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);
`ifdef SIPO_DROP_CNT_EN
      check("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
      check("t3_a_still", 32'(data_parallel_o), 32'h0001);
      ready_parallel_i = 1'b1;
      step();
      check("t3_b_valid", 32'(valid_parallel_o), 32'h1);
      check("t3_b_data", 32'(data_parallel_o), 32'h7FFE);
      step();
      check("t3_drain", 32'(valid_parallel_o), 32'h0);
      send_frame(15'h0F0F, 1'b0);
      check("t3_after_drop", 32'(data_parallel_o), 32'h0F0F);
      step();

      // Handshake in the same cycle as the next frame's first bit.
      do_reset();
      ready_parallel_i = 1'b0;
      ovf_base = ovf_cnt;
      send_frame(15'h0001, 1'b0);
      send_frame(15'h7FFE, 1'b0);
      w = 15'h5A3C;
      ready_parallel_i = 1'b1;
      send_bit(w[TBL-1]);
      check("t4_b_valid", 32'(valid_parallel_o), 32'h1);
      check("t4_b_data", 32'(data_parallel_o), 32'h7FFE);
      check("t4_no_ovf", 32'(overflow_o), 32'h0);
      for (int i = TBL - 2; i >= 0; i--) send_bit(w[i]);
      check("t4_c_valid", 32'(valid_parallel_o), 32'h1);
      check("t4_c_data", 32'(data_parallel_o), 32'h5A3C);
      check("t4_ovf_count", 32'(ovf_cnt - ovf_base), 32'd0);
      step();

      // Reset mid-frame.
      w = 15'h7FFF;
      for (int i = TBL - 1; i >= TBL - 7; i--) send_bit(w[i]);
      do_reset();
      check("t5_rst_data", 32'(data_parallel_o), 32'h0);
      check("t5_rst_valid", 32'(valid_parallel_o), 32'h0);
      check("t5_rst_ovf", 32'(overflow_o), 32'h0);
      send_frame(15'h1234, 1'b0);
      check("t5_valid", 32'(valid_parallel_o), 32'h1);
      check("t5_data", 32'(data_parallel_o), 32'h1234);
      step();

      // Many dropped frames.
      do_reset();
      ready_parallel_i = 1'b0;
      send_frame(15'h0003, 1'b0);
      send_frame(15'h6000, 1'b0);
      ovf_base = ovf_cnt;
      for (int f = 0; f < 300; f++) send_frame(15'h2222, 1'b0);
      step();
      check("t6_ovf_count", 32'(ovf_cnt - ovf_base), 32'd300);
`ifdef SIPO_DROP_CNT_EN
      check("t6_drop_sat", 32'(drop_cnt_o), 32'd255);
`endif
      check("t6_a_kept", 32'(data_parallel_o), 32'h0003);
      ready_parallel_i = 1'b1;
      step();
      check("t6_b_data", 32'(data_parallel_o), 32'h6000);
      check("t6_b_valid", 32'(valid_parallel_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
